// File: rtl/skid_pipe_reg_if.sv
// Valid/ready handshake bundle for skid_pipe_reg: upstream in_* side and downstream out_* side.
// slave is the register block's view; master is the view of whatever drives and consumes it.
interface skid_pipe_reg_if #(
  parameter int unsigned DATA_LEN = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [DATA_LEN-1:0] in_data;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_LEN-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/skid_pipe_reg.sv
// Flow-controlled pipeline register with valid/ready back-pressure and synchronous flush.
// SKID_PIPE_FULL_THROUGHPUT_EN selects the 2-entry skid buffer (registered in_ready); default is single entry.
module skid_pipe_reg #(
  parameter int unsigned          DATA_LEN = 32,
  parameter logic [DATA_LEN-1:0]  RST_DATA = '0
) (
  input logic              clk,
  input logic              rst_n,
  input logic              flush,
  skid_pipe_reg_if.slave   bus
);

  logic in_ready;
  logic in_fire;

  assign bus.in_ready = in_ready;
  assign in_fire      = bus.in_valid & in_ready;

`ifdef SKID_PIPE_FULL_THROUGHPUT_EN

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_e;

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] main_q, main_d;
  logic [DATA_LEN-1:0] skid_q, skid_d;

  // in_ready decodes only the state register, so out_ready never reaches upstream
  assign in_ready      = (state_q != S_FULL);
  assign bus.out_valid = (state_q != S_EMPTY);
  assign bus.out_data  = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = S_EMPTY;
    end else begin
      unique case (state_q)
        S_EMPTY: begin
          if (in_fire) begin
            state_d = S_ONE;
            main_d  = bus.in_data;
          end
        end
        S_ONE: begin
          if (in_fire && bus.out_ready) begin
            main_d = bus.in_data;
          end else if (in_fire) begin
            state_d = S_FULL;
            skid_d  = bus.in_data;
          end else if (bus.out_ready) begin
            state_d = S_EMPTY;
          end
        end
        S_FULL: begin
          if (bus.out_ready) begin
            state_d = S_ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = S_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_EMPTY;
      main_q  <= RST_DATA;
      skid_q  <= RST_DATA;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

`else

  logic                valid_q, valid_d;
  logic [DATA_LEN-1:0] data_q, data_d;

  // Accepting while the held entry drains keeps one transfer per cycle
  assign in_ready      = !valid_q | bus.out_ready;
  assign bus.out_valid = valid_q;
  assign bus.out_data  = data_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (in_fire) begin
      valid_d = 1'b1;
      data_d  = bus.in_data;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= RST_DATA;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

`endif

endmodule
